// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline host controller: opcodes, FSM state
// encoding, core-facing widths and the captured host command record.
package pipeline_pkg;

  localparam int IMEM_AW = 9;
  localparam int DMEM_AW = 8;
  localparam int REG_AW  = 3;
  localparam int DATA_W  = 64;
  localparam int INSTR_W = 32;
  localparam int OP_W    = 3;

  localparam logic [OP_W-1:0] OP_NOP     = 3'd0;
  localparam logic [OP_W-1:0] OP_WR_IMEM = 3'd1;
  localparam logic [OP_W-1:0] OP_WR_DMEM = 3'd2;
  localparam logic [OP_W-1:0] OP_RUN     = 3'd3;
  localparam logic [OP_W-1:0] OP_RD_REG  = 3'd4;
  localparam logic [OP_W-1:0] OP_RD_DMEM = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RUN,
    ST_DRAIN,
    ST_READ,
    ST_RESP
  } state_t;

  // Host command as presented on the command port.
  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [IMEM_AW-1:0] addr;
    logic [DATA_W-1:0]  data;
  } host_cmd_t;

  function automatic logic op_is_read(input logic [OP_W-1:0] op);
    return (op == OP_RD_REG) || (op == OP_RD_DMEM);
  endfunction

endpackage

// File: rtl/pipeline_cycle_counter.sv
// Loadable down-counter shared by the RUN, DRAIN and READ waits.
//   load/load_val : (re)start a wait of load_val cycles
//   last          : the current cycle is the final cycle of the wait
// After a load of N, last rises in the N-th following cycle. A load of 0
// behaves like 1 so a wait can never stall.
module pipeline_cycle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign last = (cnt <= CNT_W'(1));

endmodule

// File: rtl/pipeline_host_ctrl.sv
// Host-side sequencer for the 5-stage pipeline core. Takes one command at a
// time (valid/ready), turns it into preload writes, a start window of N
// cycles plus a drain, or a verification read, and returns one response.
// Ports:
//   clk, reset              clock, async active-high reset
//   cmd_*                   command channel (op/addr/data, valid/ready)
//   rsp_*                   response channel (data/err, valid/ready)
//   busy                    controller not in IDLE
//   *_pre                   I-MEM / D-MEM preload write port to core
//   start                   core run enable
//   *_raddr_ver/*_rdata_ver verification read ports
// All core-facing outputs are registered.
module pipeline_host_ctrl
  import pipeline_pkg::*;
#(
  parameter int RUN_W        = 16,
  parameter int DRAIN_CYCLES = 5,
  parameter int READ_LAT     = 1   // must be >= 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [IMEM_AW-1:0] cmd_addr,
  input  logic [DATA_W-1:0]  cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic [IMEM_AW-1:0] imem_waddr_pre,
  output logic [INSTR_W-1:0] instr_write_pre,
  output logic               instr_we_pre,
  output logic [DMEM_AW-1:0] dmem_waddr_pre,
  output logic [DATA_W-1:0]  dmem_wdata_pre,
  output logic               dmem_we_pre,
  output logic               start,
  output logic [REG_AW-1:0]  regfile_raddr_ver,
  input  logic [DATA_W-1:0]  regfile_rdata_ver,
  output logic [DMEM_AW-1:0] mem_raddr_ver,
  input  logic [DATA_W-1:0]  mem_rdata_ver
);

  state_t          state;
  host_cmd_t       cmd_in;
  logic [OP_W-1:0] cur_op;
  logic            accept;
  logic [RUN_W-1:0] run_cnt;

  logic             cnt_load;
  logic [RUN_W-1:0] cnt_val;
  logic             cnt_last;

  assign cmd_in  = '{op: cmd_op, addr: cmd_addr, data: cmd_data};
  assign accept  = cmd_valid && cmd_ready;
  assign run_cnt = cmd_in.data[RUN_W-1:0];
  assign busy    = (state != ST_IDLE);

  // One counter serves every wait: loaded on accept with the run count or
  // the read latency, reloaded with the drain length on leaving RUN.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_load = 1'b1;
          cnt_val  = (cmd_in.op == OP_RUN) ? run_cnt : RUN_W'(READ_LAT);
        end
      end
      ST_RUN: begin
        if (cnt_last) begin
          cnt_load = 1'b1;
          cnt_val  = RUN_W'(DRAIN_CYCLES);
        end
      end
      default: ;
    endcase
  end

  pipeline_cycle_counter #(.CNT_W(RUN_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      cur_op            <= OP_NOP;
      cmd_ready         <= 1'b1;
      rsp_valid         <= 1'b0;
      rsp_data          <= '0;
      rsp_err           <= 1'b0;
      imem_waddr_pre    <= '0;
      instr_write_pre   <= '0;
      instr_we_pre      <= 1'b0;
      dmem_waddr_pre    <= '0;
      dmem_wdata_pre    <= '0;
      dmem_we_pre       <= 1'b0;
      start             <= 1'b0;
      regfile_raddr_ver <= '0;
      mem_raddr_ver     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            cur_op    <= cmd_in.op;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            case (cmd_in.op)
              OP_WR_IMEM: begin
                imem_waddr_pre  <= cmd_in.addr;
                instr_write_pre <= cmd_in.data[INSTR_W-1:0];
                instr_we_pre    <= 1'b1;
                state           <= ST_WRITE;
              end
              OP_WR_DMEM: begin
                dmem_waddr_pre <= cmd_in.addr[DMEM_AW-1:0];
                dmem_wdata_pre <= cmd_in.data;
                dmem_we_pre    <= 1'b1;
                state          <= ST_WRITE;
              end
              OP_RUN: begin
                // A zero count answers straight away without touching start.
                if (run_cnt != '0) begin
                  start <= 1'b1;
                  state <= ST_RUN;
                end else begin
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
                end
              end
              OP_RD_REG: begin
                regfile_raddr_ver <= cmd_in.addr[REG_AW-1:0];
                state             <= ST_READ;
              end
              OP_RD_DMEM: begin
                mem_raddr_ver <= cmd_in.addr[DMEM_AW-1:0];
                state         <= ST_READ;
              end
              OP_NOP: begin
                rsp_valid <= 1'b1;
                state     <= ST_RESP;
              end
              default: begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                state     <= ST_RESP;
              end
            endcase
          end
        end

        // WE was raised on accept; this is its only cycle.
        ST_WRITE: begin
          instr_we_pre <= 1'b0;
          dmem_we_pre  <= 1'b0;
          rsp_valid    <= 1'b1;
          state        <= ST_RESP;
        end

        ST_RUN: begin
          if (cnt_last) begin
            start <= 1'b0;
            state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (cnt_last) begin
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end

        // Address has been stable for READ_LAT cycles when last is seen.
        ST_READ: begin
          if (cnt_last) begin
            rsp_data  <= (cur_op == OP_RD_REG) ? regfile_rdata_ver : mem_rdata_ver;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          instr_we_pre <= 1'b0;
          dmem_we_pre  <= 1'b0;
          start        <= 1'b0;
          rsp_valid    <= 1'b0;
          cmd_ready    <= 1'b1;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pipeline_host_ctrl.md
Name: pipeline_host_ctrl

Overview:
- Host-side sequencer for the 5-stage pipeline core.
- Accepts a one-at-a-time command stream (valid/ready) and turns each command into the core's preload, start and verification-read signals.
- Covers: preload I-MEM/D-MEM, run the core for N cycles, drain, then read back the register file or D-MEM.
- Sits between the host/register interface and the pipeline top; replaces hand-driven bench stimulus.

Parameters:
- RUN_W, 16, width of the run-cycle count (cmd_data[RUN_W-1:0]).
- DRAIN_CYCLES, 5, cycles with start=0 after a run, so in-flight write-backs retire.
- READ_LAT, 1, cycles between driving a verification address and sampling its rdata (minimum 1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  3  0 NOP, 1 WR_IMEM, 2 WR_DMEM, 3 RUN, 4 RD_REG, 5 RD_DMEM, 6-7 illegal
- cmd_addr  in  9  imem [8:0], dmem [7:0], reg [2:0]
- cmd_data  in  64  write data; RUN count in low RUN_W bits
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  64  read data; 0 for non-read commands
- rsp_err  out  1  illegal opcode
- busy  out  1  high in any state other than IDLE
- imem_waddr_pre  out  9  to core
- instr_write_pre  out  32  to core, equals cmd_data[31:0]
- instr_we_pre  out  1  to core
- dmem_waddr_pre  out  8  to core
- dmem_wdata_pre  out  64  to core
- dmem_we_pre  out  1  to core
- start  out  1  core run enable
- regfile_raddr_ver  out  3  to core
- regfile_rdata_ver  in  64  from core
- mem_raddr_ver  out  8  to core
- mem_rdata_ver  in  64  from core

Behaviour:
- Reset (async, any state):
  - All outputs go to 0, except cmd_ready=1.
  - State goes to IDLE; counters clear.
  - A reset during RUN deasserts start immediately.
- States:
  - IDLE: cmd_ready=1. A command is accepted when cmd_valid && cmd_ready at the clock edge; op and address/data are captured.
    - WR_IMEM / WR_DMEM → WRITE
    - RUN with count>0 → RUN
    - RUN with count=0 → RESP (no start pulse)
    - RD_REG / RD_DMEM → READ
    - NOP → RESP
    - illegal → RESP with rsp_err=1
  - WRITE: exactly one cycle with instr_we_pre=1 (or dmem_we_pre=1), captured address/data driven, then → RESP. WE is never high for more than one cycle per command.
  - RUN: start=1 for exactly count consecutive cycles (a down-counter loaded on entry), then → DRAIN.
  - DRAIN: start=0 for DRAIN_CYCLES cycles, then → RESP.
  - READ: verification address is driven and held; after READ_LAT cycles rdata is sampled into rsp_data, then → RESP.
  - RESP: rsp_valid=1, with rsp_data and rsp_err held stable until rsp_valid && rsp_ready, then → IDLE.
- Handshake rules:
  - cmd_ready=0 in every state except IDLE.
  - At most one command is outstanding.
  - cmd_valid is ignored while cmd_ready=0.
  - The response pops in the same cycle rsp_ready is seen. The next command is accepted no earlier than the following cycle (no IDLE bypass).
- Address rules:
  - Address is truncated to the target width (dmem/mem use [7:0], reg uses [2:0]); no error is flagged.
  - regfile_raddr_ver and mem_raddr_ver hold their last value outside READ.
- Latency, accept to rsp_valid:
  - write: 2 cycles
  - read: READ_LAT+1 cycles
  - run: count+DRAIN_CYCLES+1 cycles
  - NOP/illegal: 1 cycle
- Preload and start are mutually exclusive by construction: WE is never high while start=1.

Decomposition:
- Shared package pipeline_pkg holds:
  - opcode localparams OP_NOP..OP_RD_DMEM
  - state encoding
  - IMEM_AW=9, DMEM_AW=8, REG_AW=3, DATA_W=64, INSTR_W=32
- One natural sub-module, pipeline_cycle_counter: a loadable down-counter with a done flag, reused by RUN, DRAIN and READ wait.

Test Plan:
- Reset mid-RUN: reset while start=1 → start=0 and cmd_ready=1 asynchronously; rsp_valid=0.
- WR_IMEM addr 5, data 0x00009300 → exactly one cycle with instr_we_pre=1, imem_waddr_pre=5, instr_write_pre=0x00009300; rsp_valid 2 cycles after accept, rsp_data=0.
- Preload D-MEM[0]=4, I-MEM with ld R2,R0 / ld R3,R0 / NOPs / st R2,R1; RUN count=6 → start high exactly 6 cycles, then 5 low, then response.
  - RD_REG 2 returns 4.
  - RD_DMEM 4 returns 4 (was 0x64).
- RUN count=0 → no start pulse; response after 1 cycle.
- rsp_ready held low 10 cycles in RESP → rsp_valid, rsp_data stable; cmd_ready=0 throughout; cmd_valid pulses ignored.
- cmd_op=7 → rsp_err=1, no WE or start activity; next NOP returns rsp_err=0.
